uart_tx: RTL

//  Serial transmitter paired with the team's UART receiver. Same frame format
//  and 16x oversampling tick from the shared baud generator: 1 start bit,

---
 rtl/uart_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- serial transmitter, companion of the team UART receiver.
//
// Frame: 1 start bit, DBIT data bits LSB first, optional parity bit, then a
// stop period of SB_TICK oversampling ticks. Every start/data/parity bit lasts
// 16 s_ticks (16x oversampling from the shared baud generator).
//
// Parameters:
//   DBIT       data bits per frame (6..8)
//   SB_TICK    s_ticks in the stop period (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//   PARITY_EN  1 = append a parity bit after the data bits
//   PARITY_ODD parity sense when enabled (0 = even, 1 = odd)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   s_tick       16x baud tick, one clk wide
//   tx_start     send request, only looked at while idle
//   din          frame data, din[DBIT-1:0] used
//   tx_busy      high whenever the transmitter is not idle
//   tx_done_tick one-clk pulse in the cycle of the final stop tick
//   tx           serial line, idle high, straight from a flop
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam logic       PAR_INIT  = (PARITY_ODD != 0);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);

    state_t     state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        par_d        = par_q;
        tx_d         = 1'b1;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // A tick arriving together with tx_start is deliberately not
                // counted: the start bit begins with s = 0.
                if (tx_start) begin
                    s_d     = '0;
                    b_d     = din;
                    par_d   = PAR_INIT;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                tx_d = b_q[0];
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d   = '0;
                        b_d   = {1'b0, b_q[7:1]};
                        // Parity accumulates each bit as it leaves the shifter.
                        par_d = par_q ^ b_q[0];
                        if (n_q == N_LAST) begin
                            state_d = HAS_PAR ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            PARITY: begin
                tx_d = par_q;
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        tx_done_tick = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_busy = (state_q != IDLE);
    assign tx      = tx_q;

endmodule
